// File: rtl/mem_stage.sv
// Memory stage with a small multi-cycle data memory and a MEM/WB register set.
// A load or store stalls upstream (ready low) for WAIT_CYCLES+1 cycles, then
// completes with a single ready-high cycle in which MEM/WB captures.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access in flight; pass-through when no request
// ACCESS | wait counter running; store commits / load latches at zero
// DONE   | access finished; MEM/WB captures, back to IDLE
module mem_stage #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] DATA_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] ST_Val,
    input  logic [4:0]  Dest_in,
    output logic        ready,
    output logic        WB_EN,
    output logic        WB_MEM_R_EN,
    output logic [31:0] WB_ALU_Res,
    output logic [31:0] WB_Mem_Res,
    output logic [4:0]  WB_Dest
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  cnt;
    logic [31:0] mem [0:63];
    logic [31:0] load_data;
    logic [31:0] offset;
    logic        in_range;
    logic [5:0]  word_idx;
    logic        req;
    logic        commit;
    logic        unused_addr_bits;

    // Unsigned subtraction makes addresses below the base wrap far out of range.
    assign offset           = ALU_Res - DATA_BASE;
    assign in_range         = (offset[31:8] == 24'd0);
    assign word_idx         = offset[7:2];
    assign unused_addr_bits = ^offset[1:0];

    assign req    = MEM_R_EN_in | MEM_W_EN_in;
    assign commit = (state == ACCESS) && (cnt == 4'd0);
    assign ready  = (state == DONE) || ((state == IDLE) && !req);

    // Next-state decode for the access sequencer.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = req ? ACCESS : IDLE;
            ACCESS:  state_nxt = (cnt == 4'd0) ? DONE : ACCESS;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and wait down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:    if (req) cnt <= CNT_LOAD;
                ACCESS:  if (cnt != 4'd0) cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Data memory write; reset forces IDLE so an in-flight store never commits.
    always_ff @(posedge clk) begin
        if (commit && MEM_W_EN_in && in_range) begin
            mem[word_idx] <= ST_Val;
        end
    end

    // Latch load data at commit; stores (including load+store) return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_data <= 32'd0;
        end else if (commit) begin
            load_data <= (!MEM_W_EN_in && in_range) ? mem[word_idx] : 32'd0;
        end
    end

    // MEM/WB pipeline registers, frozen while ready is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN       <= 1'b0;
            WB_MEM_R_EN <= 1'b0;
            WB_ALU_Res  <= 32'd0;
            WB_Mem_Res  <= 32'd0;
            WB_Dest     <= 5'd0;
        end else if (ready) begin
            WB_EN       <= WB_EN_in;
            WB_MEM_R_EN <= MEM_R_EN_in;
            WB_ALU_Res  <= ALU_Res;
            WB_Mem_Res  <= (state == DONE) ? load_data : 32'd0;
            WB_Dest     <= Dest_in;
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_Stage

Interface
REQ-001 The block SHALL have a parameter WAIT_CYCLES, default 4, giving the number of access cycles per memory operation; legal values are 1 to 15.
REQ-002 The block SHALL have a parameter DATA_BASE, default 1024, giving the byte address of data word 0.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 WB_EN_in  input  1  the instruction writes back a register.
REQ-006 MEM_R_EN_in  input  1  load request.
REQ-007 MEM_W_EN_in  input  1  store request.
REQ-008 ALU_Res  input  32  byte address for loads/stores; pass-through result otherwise.
REQ-009 ST_Val  input  32  store data (Reg2 value from execute).
REQ-010 Dest_in  input  5  destination register number.
REQ-011 ready  output  1  high when the current instruction completes this cycle; low means freeze all upstream stages.
REQ-012 WB_EN, WB_MEM_R_EN  output  1 each  registered copies of WB_EN_in and MEM_R_EN_in to write-back.
REQ-013 WB_ALU_Res, WB_Mem_Res  output  32 each  registered ALU result and load data.
REQ-014 WB_Dest  output  5  registered destination.

Function
REQ-015 The block SHALL contain 64 x 32-bit data words; word index = (ALU_Res - DATA_BASE)[7:2]; address bits [1:0] are ignored.
REQ-016 An address is in range when 0 <= ALU_Res - DATA_BASE <= 255 (unsigned compare after subtraction); out-of-range stores SHALL be dropped and out-of-range loads SHALL return 0.
REQ-017 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-018 In IDLE with no request (both enables low): ready=1, and the MEM/WB registers capture the inputs at the clock edge, with WB_Mem_Res=0; latency 1 cycle.
REQ-019 In IDLE with a request: ready=0, the next state is ACCESS, and the counter loads WAIT_CYCLES-1.
REQ-020 In ACCESS: ready=0; if the counter is nonzero it decrements; if it is zero, the store is committed or the load word is latched internally, and the next state is DONE.
REQ-021 In DONE: ready=1; the MEM/WB registers capture the inputs plus the latched load data (0 for stores); the next state is IDLE.
REQ-022 A memory operation SHALL hold ready low for exactly WAIT_CYCLES+1 cycles, followed by 1 cycle high.
REQ-023 Upstream holds all inputs stable while ready=0; the block SHALL sample ST_Val and ALU_Res only at the commit cycle.
REQ-024 When MEM_R_EN_in and MEM_W_EN_in are both high, the block SHALL perform the store only, and WB_Mem_Res SHALL be 0.
REQ-025 The MEM/WB registers SHALL hold their values in every cycle in which ready=0.
REQ-026 Each store SHALL be committed exactly once per instruction, and never during IDLE or DONE.
REQ-027 A request arriving in the cycle after DONE SHALL start a new operation from IDLE with no lost cycle beyond REQ-022.

Reset
REQ-028 When rst=0, the block SHALL force the FSM to IDLE, the counter to 0, and all WB_* outputs to 0; ready then follows REQ-018.
REQ-029 Reset SHALL NOT clear the data memory; a store that has not yet reached its commit cycle when reset asserts SHALL be aborted and leave memory unchanged.
REQ-030 Reset deassertion SHALL NOT trigger any memory access without a request.

Verification (WAIT_CYCLES=4, DATA_BASE=1024)
REQ-031 No-memory instruction (WB_EN_in=1, Dest_in=5, ALU_Res=0x1234) -> ready stays 1; after 1 edge, WB_ALU_Res=0x1234, WB_Dest=5, WB_EN=1.
REQ-032 Store ALU_Res=1028, ST_Val=0xDEADBEEF -> ready low 5 cycles, then high 1 cycle; a following load from 1028 (or 1031) -> WB_Mem_Res=0xDEADBEEF, WB_MEM_R_EN=1.
REQ-033 Load from ALU_Res=0 and load from 1280 -> WB_Mem_Res=0; a store to 1280 leaves all 64 words unchanged.
REQ-034 Store 0x11111111 to 1032, then a store of 0x22222222 to 1032 with rst pulsed low during its 2nd ACCESS cycle -> after reset, a load from 1032 returns 0x11111111 and ready=1 with WB_* = 0 immediately after reset.
REQ-035 Back-to-back load(1028) then store(1036, 0x5A5A5A5A) then load(1036) -> 18 total cycles, exactly three ready pulses, and the final WB_Mem_Res=0x5A5A5A5A.
REQ-036 Both enables high (ALU_Res=1040, ST_Val=7) -> word 4 = 7, and WB_Mem_Res=0 in the DONE capture.
